// File: rtl/leds_seq_pkg.sv
// Shared types and constants for the LED sequencer: register map, CTRL layout,
// the sequencing modes and the FSM state encoding.
package leds_seq_pkg;

    localparam int DEF_PERIOD_W = 24;
    localparam int DEF_STEP_W   = 16;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_PATTERN = 2'd1;
    localparam logic [1:0] ADDR_PERIOD  = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_ROTL   = 2'b10,
        MODE_ROTR   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    typedef struct packed {
        mode_e mode;
        logic  en;
    } ctrl_t;

endpackage

// File: rtl/leds_seq_if.sv
// CPU-side register bus of the LED sequencer: one-cycle write/read strobes,
// 2-bit register select, write data and registered read data.
interface leds_seq_if;

    logic        we_i;
    logic        re_i;
    logic [1:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;

    modport master (
        output we_i,
        output re_i,
        output addr_i,
        output wdata_i,
        input  rdata_o
    );

    modport slave (
        input  we_i,
        input  re_i,
        input  addr_i,
        input  wdata_i,
        output rdata_o
    );

endinterface

// File: rtl/leds_seq_prescaler.sv
// Reloadable down-counter that paces the sequencer; tick_o flags cnt==0 and the
// counter reloads from period_i on load_i or on an enabled tick.
module leds_seq_prescaler #(
    parameter int PERIOD_W = 24
) (
    input  logic                clck_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic                enable_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                tick_o
);

    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] cnt_d;

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = period_i;
        end else if (enable_i) begin
            if (cnt_q == '0) cnt_d = period_i;
            else             cnt_d = cnt_q - {{(PERIOD_W-1){1'b0}}, 1'b1};
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clck_i) begin
        if (!rst_i) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/leds_sequencer.sv
// Memory-mapped LED sequencer: issues timed static/blink/rotate write pulses to
// the LED register. Define LEDS_SEQ_READBACK_EN to build the read path and STATUS.
module leds_sequencer
    import leds_seq_pkg::*;
#(
    parameter int PERIOD_W = DEF_PERIOD_W,
    parameter int STEP_W   = DEF_STEP_W
) (
    input  logic        clck_i,
    input  logic        rst_i,
    leds_seq_if.slave   bus,
    output logic [31:0] leds_data_o,
    output logic        leds_we_o,
    output logic        busy_o
);

    ctrl_t               ctrl_q,      ctrl_d;
    logic [31:0]         pattern_q,   pattern_d;
    logic [PERIOD_W-1:0] period_q,    period_d;
    state_e              state_q,     state_d;
    logic [31:0]         cur_q,       cur_d;
    logic                phase_q,     phase_d;
    logic [STEP_W-1:0]   step_q,      step_d;
    logic [31:0]         leds_data_q, leds_data_d;
    logic                leds_we_q,   leds_we_d;

    logic wr_ctrl, wr_pattern, wr_period;
    logic wr_enable, wr_disable, redirect, tick;

    assign wr_ctrl    = bus.we_i && (bus.addr_i == ADDR_CTRL);
    assign wr_pattern = bus.we_i && (bus.addr_i == ADDR_PATTERN);
    assign wr_period  = bus.we_i && (bus.addr_i == ADDR_PERIOD);
    assign wr_enable  = wr_ctrl &&  bus.wdata_i[CTRL_EN_BIT];
    assign wr_disable = wr_ctrl && !bus.wdata_i[CTRL_EN_BIT];
    // A running sequence restarts on a CTRL enable or a new pattern; such a write
    // beats a coincident step.
    assign redirect   = wr_enable || wr_pattern;

    leds_seq_prescaler #(.PERIOD_W(PERIOD_W)) u_prescaler (
        .clck_i   (clck_i),
        .rst_i    (rst_i),
        .load_i   (state_q == ST_LOAD),
        .enable_i ((state_q == ST_RUN) && !redirect && !wr_disable),
        .period_i (period_q),
        .tick_o   (tick)
    );

    always_comb begin
        ctrl_d      = ctrl_q;
        pattern_d   = pattern_q;
        period_d    = period_q;
        state_d     = state_q;
        cur_d       = cur_q;
        phase_d     = phase_q;
        step_d      = step_q;
        leds_data_d = leds_data_q;
        leds_we_d   = 1'b0;

        if (wr_ctrl) begin
            ctrl_d.en   = bus.wdata_i[CTRL_EN_BIT];
            ctrl_d.mode = mode_e'(bus.wdata_i[CTRL_MODE_MSB:CTRL_MODE_LSB]);
        end
        if (wr_pattern) pattern_d = bus.wdata_i;
        if (wr_period)  period_d  = bus.wdata_i[PERIOD_W-1:0];

        unique case (state_q)
            ST_IDLE: begin
                if (wr_enable) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d     = ST_RUN;
                cur_d       = pattern_q;
                phase_d     = 1'b1;
                step_d      = '0;
                leds_data_d = pattern_q;
                leds_we_d   = 1'b1;
            end
            ST_RUN: begin
                if (redirect) begin
                    state_d = ST_LOAD;
                end else if (tick) begin
                    step_d = step_q + {{(STEP_W-1){1'b0}}, 1'b1};
                    unique case (ctrl_q.mode)
                        MODE_STATIC: ;
                        MODE_BLINK: begin
                            phase_d     = !phase_q;
                            leds_data_d = phase_q ? 32'h0 : pattern_q;
                            leds_we_d   = 1'b1;
                        end
                        MODE_ROTL: begin
                            cur_d       = {cur_q[30:0], cur_q[31]};
                            leds_data_d = {cur_q[30:0], cur_q[31]};
                            leds_we_d   = 1'b1;
                        end
                        MODE_ROTR: begin
                            cur_d       = {cur_q[0], cur_q[31:1]};
                            leds_data_d = {cur_q[0], cur_q[31:1]};
                            leds_we_d   = 1'b1;
                        end
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Disabling wins from any state; an active sequence blanks the LEDs on exit.
        if (wr_disable) begin
            state_d = ST_IDLE;
            if (state_q != ST_IDLE) begin
                leds_data_d = 32'h0;
                leds_we_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clck_i) begin
        if (!rst_i) begin
            ctrl_q      <= '0;
            pattern_q   <= '0;
            period_q    <= '0;
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            phase_q     <= 1'b0;
            step_q      <= '0;
            leds_data_q <= '0;
            leds_we_q   <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            pattern_q   <= pattern_d;
            period_q    <= period_d;
            state_q     <= state_d;
            cur_q       <= cur_d;
            phase_q     <= phase_d;
            step_q      <= step_d;
            leds_data_q <= leds_data_d;
            leds_we_q   <= leds_we_d;
        end
    end

    assign leds_data_o = leds_data_q;
    assign leds_we_o   = leds_we_q;
    assign busy_o      = (state_q != ST_IDLE);

`ifdef LEDS_SEQ_READBACK_EN
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] status_w;

    always_comb begin
        status_w               = '0;
        status_w[0]            = busy_o;
        status_w[1]            = phase_q;
        status_w[STEP_W+7:8]   = step_q;

        rdata_d = rdata_q;
        if (bus.re_i) begin
            unique case (bus.addr_i)
                ADDR_CTRL:    rdata_d = {29'h0, ctrl_q.mode, ctrl_q.en};
                ADDR_PATTERN: rdata_d = pattern_q;
                ADDR_PERIOD:  rdata_d = {{(32-PERIOD_W){1'b0}}, period_q};
                ADDR_STATUS:  rdata_d = status_w;
            endcase
        end
    end

    always_ff @(posedge clck_i) begin
        if (!rst_i) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign bus.rdata_o = rdata_q;
`else
    assign bus.rdata_o = 32'h0;
`endif

endmodule

// File: tb/tb_leds_sequencer.sv
// Self-checking bench for leds_sequencer: table-driven mode scenarios plus
// hand-written collision, reset and register-access sequences, scored by a pulse queue.
module tb_leds_sequencer;

    logic        clck_i = 1'b0;
    logic        rst_i  = 1'b0;
    logic [31:0] leds_data_o;
    logic        leds_we_o;
    logic        busy_o;

    leds_seq_if bus ();

    leds_sequencer dut (
        .clck_i      (clck_i),
        .rst_i       (rst_i),
        .bus         (bus),
        .leds_data_o (leds_data_o),
        .leds_we_o   (leds_we_o),
        .busy_o      (busy_o)
    );

    always #5 clck_i = ~clck_i;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    always @(posedge clck_i) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } pulse_t;

    pulse_t sb[$];

    typedef struct {
        logic [31:0]       period;
        logic [31:0]       pattern;
        logic [31:0]       ctrl;
        int                n;
        logic [3:0][31:0]  data;
        int                stop_off;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [31:0] v);
`ifdef LEDS_SEQ_READBACK_EN
        return v;
`else
        return 32'h0;
`endif
    endfunction

    // Every observed pulse must match the head of the queue in cycle and data.
    always @(negedge clck_i) begin
        if (mon_en && leds_we_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual=0x%08h at cycle %0d expected=none", leds_data_o, cyc);
            end else begin
                pulse_t p;
                p = sb.pop_front();
                check("pulse_cycle", cyc, p.cyc);
                check("pulse_data", leds_data_o, p.data);
            end
        end
    end

    task automatic push(input int c, input logic [31:0] d);
        pulse_t p;
        p.cyc  = c;
        p.data = d;
        sb.push_back(p);
    endtask

    // Called at a falling edge; the write is sampled at the next rising edge (E0).
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, output int e0);
        bus.we_i    = 1'b1;
        bus.addr_i  = a;
        bus.wdata_i = d;
        e0 = cyc + 1;
        @(negedge clck_i);
        bus.we_i = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.re_i   = 1'b1;
        bus.addr_i = a;
        @(negedge clck_i);
        bus.re_i = 1'b0;
        d = bus.rdata_o;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clck_i);
    endtask

    task automatic drain(input string name, input int n);
        repeat (n) @(negedge clck_i);
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          e0, e1, t;
        logic [31:0] rd;

        vecs[0] = '{period: 32'd5,         pattern: 32'h0000_00F0, ctrl: 32'h1, n: 1,
                    data: {32'h0, 32'h0, 32'h0, 32'h0000_00F0}, stop_off: 101};
        vecs[1] = '{period: 32'hFF00_0003, pattern: 32'h0000_00A5, ctrl: 32'h3, n: 4,
                    data: {32'h0, 32'h0000_00A5, 32'h0, 32'h0000_00A5}, stop_off: 16};
        vecs[2] = '{period: 32'd0,         pattern: 32'h8000_0001, ctrl: 32'h5, n: 3,
                    data: {32'h0, 32'h0000_0006, 32'h0000_0003, 32'h8000_0001}, stop_off: 3};
        vecs[3] = '{period: 32'd1,         pattern: 32'h0000_0003, ctrl: 32'h7, n: 3,
                    data: {32'h0, 32'hC000_0000, 32'h8000_0001, 32'h0000_0003}, stop_off: 6};

        bus.we_i = 1'b0; bus.re_i = 1'b0; bus.addr_i = 2'd0; bus.wdata_i = 32'h0;
        repeat (3) @(negedge clck_i);
        rst_i  = 1'b1;
        mon_en = 1'b1;
        @(negedge clck_i);
        check("reset_leds_we", {31'h0, leds_we_o}, 32'h0);
        check("reset_leds_data", leds_data_o, 32'h0);
        check("reset_busy", {31'h0, busy_o}, 32'h0);
        check("reset_rdata", bus.rdata_o, 32'h0);

        // Mode scenarios: LOAD pulse at E1, steps every PERIOD+1 edges, then a
        // disabling CTRL write that blanks the LEDs.
        for (int v = 0; v < 4; v++) begin
            bus_write(ADDR_PERIOD_C(), vecs[v].period, e0);
            bus_write(2'd1, vecs[v].pattern, e0);
            bus_write(2'd0, vecs[v].ctrl, e0);
            e1 = e0 + 1;
            for (int i = 0; i < vecs[v].n; i++)
                push(e1 + i * (vecs[v].period[23:0] + 1), vecs[v].data[i]);
            check($sformatf("busy_run_%0d", v), {31'h0, busy_o}, 32'h1);
            wait_until(e1 + vecs[v].stop_off - 1);
            push(e1 + vecs[v].stop_off, 32'h0);
            bus_write(2'd0, 32'h0, e0);
            check($sformatf("busy_idle_%0d", v), {31'h0, busy_o}, 32'h0);
            drain($sformatf("drained_%0d", v), 10);
        end

        // Rotate-right: a PATTERN write on the cnt==0 cycle discards the step.
        bus_write(2'd2, 32'd3, e0);
        bus_write(2'd1, 32'h0000_0001, e0);
        bus_write(2'd0, 32'h7, e0);
        e1 = e0 + 1;
        push(e1, 32'h0000_0001);
        t = e1 + 4;
        wait_until(t - 1);
        push(t + 1, 32'h0000_0F00);
        bus_write(2'd1, 32'h0000_0F00, e0);
        check("collision_e0", e0, t);
        bus_read(2'd3, rd);
        check("collision_status", rd, exp_rd(32'h0000_0003));
        push(cyc + 1, 32'h0);
        bus_write(2'd0, 32'h0, e0);
        drain("collision_drained", 10);

        // Reset for one cycle mid-blink, on the edge that would have stepped.
        bus_write(2'd2, 32'd1, e0);
        bus_write(2'd1, 32'h0000_00FF, e0);
        bus_write(2'd0, 32'h3, e0);
        e1 = e0 + 1;
        push(e1, 32'h0000_00FF);
        wait_until(e1 + 1);
        check("pre_reset_data", leds_data_o, 32'h0000_00FF);
        rst_i = 1'b0;
        @(negedge clck_i);
        rst_i = 1'b1;
        check("midreset_leds_we", {31'h0, leds_we_o}, 32'h0);
        check("midreset_leds_data", leds_data_o, 32'h0);
        check("midreset_busy", {31'h0, busy_o}, 32'h0);
        check("midreset_rdata", bus.rdata_o, 32'h0);
        drain("midreset_drained", 20);
        bus_read(2'd3, rd);
        check("midreset_status", rd, 32'h0);
        bus_read(2'd0, rd);
        check("midreset_ctrl", rd, 32'h0);

        // Register access while idle: masking, truncation, read-only STATUS.
        bus_write(2'd0, 32'hFFFF_FFF6, e0);
        bus_read(2'd0, rd);
        check("rd_ctrl", rd, exp_rd(32'h0000_0006));
        bus_write(2'd1, 32'h1234_5678, e0);
        bus_read(2'd1, rd);
        check("rd_pattern", rd, exp_rd(32'h1234_5678));
        bus_write(2'd2, 32'hABCD_EF12, e0);
        bus_read(2'd2, rd);
        check("rd_period", rd, exp_rd(32'h00CD_EF12));
        bus_write(2'd3, 32'hFFFF_FFFF, e0);
        bus_read(2'd3, rd);
        check("rd_status", rd, 32'h0);
        check("idle_busy", {31'h0, busy_o}, 32'h0);
        drain("idle_drained", 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic [1:0] ADDR_PERIOD_C();
        return 2'd2;
    endfunction

endmodule
